// File: rtl/rice_bus_if.sv
// rice_bus_if: generic request/response bus with non-posted writes.
//   request_valid/request_ready  request handshake (master -> slave)
//   request_write                1 = write, 0 = read
//   address, request_data        request payload, held stable while request_valid && !request_ready
//   response_valid/ready         response handshake (slave -> master)
//   response_data                read data
//   response_error               access rejected by the slave
interface rice_bus_if #(
  parameter int unsigned AddrWidth = 12,
  parameter int unsigned DataWidth = 32
);
  logic                 request_valid;
  logic                 request_ready;
  logic                 request_write;
  logic [AddrWidth-1:0] address;
  logic [DataWidth-1:0] request_data;
  logic                 response_valid;
  logic                 response_ready;
  logic [DataWidth-1:0] response_data;
  logic                 response_error;

  modport master (
    output request_valid, request_write, address, request_data, response_ready,
    input  request_ready, response_valid, response_data, response_error
  );

  modport slave (
    input  request_valid, request_write, address, request_data, response_ready,
    output request_ready, response_valid, response_data, response_error
  );
endinterface

// File: rtl/rice_core_csr_access.sv
// rice_core_csr_access: Zicsr execution unit of the rice core.
// Runs CSRRW/CSRRS/CSRRC (and immediate forms) as a read phase and/or a write phase on the
// CSR bus, returns the old CSR value for rd, and raises an illegal-instruction indication on
// bus errors or writes to read-only CSRs.
//
// Ports:
//   i_clk, i_rst_n    clock, asynchronous active-low reset
//   i_valid/o_ready   instruction handshake; accepted only in idle
//   i_funct3          Zicsr funct3 (001 RW, 010 RS, 011 RC, 101/110/111 immediate forms)
//   i_address         CSR address
//   i_rs1_value       register operand
//   i_uimm            immediate operand / rs1 index (zero test for RS/RC write suppression)
//   i_rd_zero         rd is x0 (suppresses the read of RW forms)
//   i_flush           kill the current instruction
//   o_done            one-cycle completion pulse
//   o_result          old CSR value (0 when no read was performed)
//   o_rd_write        write o_result to rd
//   o_illegal         illegal-instruction exception
//   csr_if            CSR bus master port
module rice_core_csr_access #(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_funct3,
  input  logic [11:0]     i_address,
  input  logic [XLEN-1:0] i_rs1_value,
  input  logic [4:0]      i_uimm,
  input  logic            i_rd_zero,
  input  logic            i_flush,
  output logic            o_done,
  output logic [XLEN-1:0] o_result,
  output logic            o_rd_write,
  output logic            o_illegal,
  rice_bus_if.master      csr_if
);

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdRsp,
    StWrReq,
    StWrRsp,
    StDone
  } state_e;

  // funct3[1:0] encodings of the operation
  localparam logic [1:0] OpRw = 2'b01;
  localparam logic [1:0] OpRs = 2'b10;

  state_e            r_state;
  state_e            w_state_next;
  logic [1:0]        r_op;
  logic [XLEN-1:0]   r_operand;
  logic [11:0]       r_address;
  logic              r_do_read;
  logic              r_do_write;
  logic [XLEN-1:0]   r_old;
  logic              r_illegal;
  logic              r_killed;

  logic [XLEN-1:0]   w_operand;
  logic              w_is_rw;
  logic              w_src_zero;
  logic              w_do_read;
  logic              w_do_write;
  logic              w_read_only;
  logic              w_accept;
  logic              w_killed;
  logic              w_rd_rsp;
  logic              w_wr_rsp;
  logic [XLEN-1:0]   w_wdata;

  // Decode of the instruction presented at the inputs (only meaningful in idle).
  always_comb begin
    w_operand   = i_funct3[2] ? {{(XLEN-5){1'b0}}, i_uimm} : i_rs1_value;
    w_is_rw     = (i_funct3[1:0] == OpRw);
    w_src_zero  = (i_uimm == 5'd0);
    w_do_read   = !(w_is_rw && i_rd_zero);
    w_do_write  = w_is_rw || !w_src_zero;
    w_read_only = (i_address[11:10] == 2'b11) && w_do_write;
    w_accept    = (r_state == StIdle) && i_valid && !i_flush;
  end

  // A flush in the same cycle as a response counts, so the drain ends right there.
  assign w_killed = r_killed || i_flush;
  assign w_rd_rsp = (r_state == StRdRsp) && csr_if.response_valid;
  assign w_wr_rsp = (r_state == StWrRsp) && csr_if.response_valid;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (w_read_only) begin
            w_state_next = StDone;
          end else if (w_do_read) begin
            w_state_next = StRdReq;
          end else begin
            w_state_next = StWrReq;
          end
        end
      end
      StRdReq: begin
        // Request stays up until taken, even when killed.
        if (csr_if.request_ready) begin
          w_state_next = StRdRsp;
        end
      end
      StRdRsp: begin
        if (csr_if.response_valid) begin
          if (w_killed) begin
            w_state_next = StIdle;
          end else if (csr_if.response_error || !r_do_write) begin
            w_state_next = StDone;
          end else begin
            w_state_next = StWrReq;
          end
        end
      end
      StWrReq: begin
        if (csr_if.request_ready) begin
          w_state_next = StWrRsp;
        end
      end
      StWrRsp: begin
        if (csr_if.response_valid) begin
          w_state_next = w_killed ? StIdle : StDone;
        end
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_op       <= 2'b00;
      r_operand  <= '0;
      r_address  <= '0;
      r_do_read  <= 1'b0;
      r_do_write <= 1'b0;
      r_old      <= '0;
      r_illegal  <= 1'b0;
      r_killed   <= 1'b0;
    end else begin
      r_state <= w_state_next;

      if (r_state == StIdle) begin
        r_killed <= 1'b0;
      end else if (i_flush) begin
        r_killed <= 1'b1;
      end

      if (w_accept) begin
        r_op       <= i_funct3[1:0];
        r_operand  <= w_operand;
        r_address  <= i_address;
        r_do_read  <= w_do_read && !w_read_only;
        r_do_write <= w_do_write;
        // Result reads as zero unless a read phase later overwrites it.
        r_old      <= '0;
        r_illegal  <= w_read_only;
      end

      if (w_rd_rsp) begin
        r_old <= csr_if.response_data;
        if (csr_if.response_error) begin
          r_illegal <= 1'b1;
        end
      end

      if (w_wr_rsp && csr_if.response_error) begin
        r_illegal <= 1'b1;
      end
    end
  end

  // Write data is a function of registered operand and captured old value only.
  always_comb begin
    case (r_op)
      OpRw:    w_wdata = r_operand;
      OpRs:    w_wdata = r_old | r_operand;
      default: w_wdata = r_old & ~r_operand;
    endcase
  end

  assign csr_if.request_valid  = (r_state == StRdReq) || (r_state == StWrReq);
  assign csr_if.request_write  = (r_state == StWrReq);
  assign csr_if.address        = r_address;
  assign csr_if.request_data   = w_wdata;
  assign csr_if.response_ready = (r_state == StRdRsp) || (r_state == StWrRsp);

  assign o_ready    = (r_state == StIdle);
  assign o_done     = (r_state == StDone);
  assign o_result   = r_old;
  assign o_rd_write = o_done && r_do_read && !r_illegal;
  assign o_illegal  = o_done && r_illegal;

endmodule

// File: tb/tb_rice_core_csr_access.sv
module tb_rice_core_csr_access;
  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            i_valid;
  logic            o_ready;
  logic [2:0]      i_funct3;
  logic [11:0]     i_address;
  logic [XLEN-1:0] i_rs1_value;
  logic [4:0]      i_uimm;
  logic            i_rd_zero;
  logic            i_flush;
  logic            o_done;
  logic [XLEN-1:0] o_result;
  logic            o_rd_write;
  logic            o_illegal;

  rice_bus_if #(12, XLEN) bus ();

  rice_core_csr_access #(.XLEN(XLEN)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_funct3    (i_funct3),
    .i_address   (i_address),
    .i_rs1_value (i_rs1_value),
    .i_uimm      (i_uimm),
    .i_rd_zero   (i_rd_zero),
    .i_flush     (i_flush),
    .o_done      (o_done),
    .o_result    (o_result),
    .o_rd_write  (o_rd_write),
    .o_illegal   (o_illegal),
    .csr_if      (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // CSR contents as seen by the bench; only the main initial block writes it.
  logic [XLEN-1:0] ref_mem [4096];

  typedef struct packed {
    logic            wr;
    logic [11:0]     addr;
    logic [XLEN-1:0] data;
  } txn_t;

  txn_t log_q[$];
  txn_t exp_q[$];

  // Slave: stall_cfg cycles of request_ready low per request, response one cycle later.
  int unsigned     stall_cfg = 0;
  bit              err_cfg = 1'b0;
  int unsigned     wait_cnt;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_err;

  assign bus.request_ready  = (wait_cnt >= stall_cfg);
  assign bus.response_valid = rsp_valid;
  assign bus.response_data  = rsp_data;
  assign bus.response_error = rsp_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= 0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (rsp_valid && bus.response_ready) rsp_valid <= 1'b0;
      if (bus.request_valid && bus.request_ready) begin
        wait_cnt <= 0;
        log_q.push_back('{wr: bus.request_write, addr: bus.address, data: bus.request_data});
        rsp_valid <= 1'b1;
        rsp_err   <= err_cfg;
        rsp_data  <= ref_mem[bus.address];
      end else if (bus.request_valid) begin
        wait_cnt <= wait_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: expected outcome of one instruction from the Zicsr rules.
  task automatic model(input logic [2:0] f3, input logic [11:0] a, input logic [XLEN-1:0] rs1,
                       input logic [4:0] uimm, input bit rdz, input int unsigned stall,
                       input bit err, output bit ill, output bit rdw, output logic [XLEN-1:0] res,
                       output int cyc, output bit chk_res, output bit mem_wr,
                       output logic [XLEN-1:0] wd);
    logic [XLEN-1:0] opnd;
    logic [XLEN-1:0] old;
    bit rd;
    bit wr;
    opnd = f3[2] ? {27'd0, uimm} : rs1;
    rd = !(f3[1:0] == 2'b01 && rdz);
    wr = (f3[1:0] == 2'b01) || (uimm != 5'd0);
    exp_q.delete();
    ill = 0; rdw = 0; res = '0; cyc = 1; chk_res = 1; mem_wr = 0; wd = '0;
    if (a[11:10] == 2'b11 && wr) begin
      ill = 1;
      return;
    end
    old = ref_mem[a];
    if (rd) begin
      exp_q.push_back('{wr: 1'b0, addr: a, data: '0});
      cyc += 2 + int'(stall);
      res = old;
      if (err) begin
        ill = 1;
        chk_res = 0;
        return;
      end
    end
    if (wr) begin
      if (f3[1:0] == 2'b01) wd = opnd;
      else if (f3[1:0] == 2'b10) wd = old | opnd;
      else wd = old & ~opnd;
      exp_q.push_back('{wr: 1'b1, addr: a, data: wd});
      cyc += 2 + int'(stall);
      if (err) ill = 1;
      else mem_wr = 1;
    end
    rdw = rd && !ill;
  endtask

  // Issue one instruction at a negedge with the DUT idle, then check everything it does.
  // flush_cyc >= 0 pulses i_flush at that cycle; it is only used during the first bus phase.
  task automatic run(input string tag, input logic [2:0] f3, input logic [11:0] a,
                     input logic [XLEN-1:0] rs1, input logic [4:0] uimm, input bit rdz,
                     input int unsigned stall, input bit err, input int flush_cyc);
    bit ill, rdw, chk_res, mem_wr, stop, prev_stall;
    logic [XLEN-1:0] res, wd, prev_d;
    logic [11:0] prev_a;
    logic prev_w;
    int cyc, n, dones;
    model(f3, a, rs1, uimm, rdz, stall, err, ill, rdw, res, cyc, chk_res, mem_wr, wd);
    if (flush_cyc >= 0) begin
      while (exp_q.size() > 1) void'(exp_q.pop_back());
      mem_wr = 0;
    end
    stall_cfg = stall;
    err_cfg = err;
    log_q.delete();
    check({tag, " ready_before"}, o_ready, 1);
    i_valid = 1'b1; i_funct3 = f3; i_address = a; i_rs1_value = rs1;
    i_uimm = uimm; i_rd_zero = rdz;
    @(negedge clk);
    i_valid = 1'b0;
    i_funct3 = 3'($urandom); i_address = 12'($urandom); i_rs1_value = $urandom;
    n = 1; dones = 0; stop = 0; prev_stall = 0;
    prev_a = '0; prev_d = '0; prev_w = 1'b0;
    while (!stop) begin
      if (prev_stall) begin
        check({tag, " stall_valid"}, bus.request_valid, 1);
        check({tag, " stall_addr"}, bus.address, prev_a);
        check({tag, " stall_data"}, bus.request_data, prev_d);
        check({tag, " stall_write"}, bus.request_write, prev_w);
      end
      prev_stall = bus.request_valid && !bus.request_ready;
      prev_a = bus.address; prev_d = bus.request_data; prev_w = bus.request_write;
      if (o_done) dones++;
      if (flush_cyc < 0 && (o_done || n >= 200)) stop = 1;
      else if (flush_cyc >= 0 && n >= flush_cyc + 20) stop = 1;
      else begin
        i_flush = (n == flush_cyc);
        @(negedge clk);
        n++;
      end
    end
    i_flush = 1'b0;
    if (flush_cyc >= 0) begin
      check({tag, " no_done"}, dones, 0);
      check({tag, " ready_after_flush"}, o_ready, 1);
    end else begin
      check({tag, " done_cycle"}, n, cyc);
      check({tag, " illegal"}, o_illegal, ill);
      check({tag, " rd_write"}, o_rd_write, rdw);
      if (chk_res) check({tag, " result"}, o_result, res);
    end
    check({tag, " ntxn"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      check({tag, " txn_write"}, log_q[i].wr, exp_q[i].wr);
      check({tag, " txn_addr"}, log_q[i].addr, exp_q[i].addr);
      if (exp_q[i].wr) check({tag, " txn_data"}, log_q[i].data, exp_q[i].data);
    end
    @(negedge clk);
    check({tag, " done_pulse"}, o_done, 0);
    check({tag, " ready_next"}, o_ready, 1);
    if (mem_wr) ref_mem[a] = wd;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f3s [6];
    logic [11:0] addrs [7];
    logic [11:0] a;
    f3s = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
    addrs = '{12'h300, 12'h340, 12'h305, 12'hC00, 12'hC01, 12'hF11, 12'h7C0};
    for (int i = 0; i < 4096; i++) ref_mem[i] = $urandom;
    rst_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_funct3 = 3'b001; i_address = '0;
    i_rs1_value = '0; i_uimm = '0; i_rd_zero = 1'b0;

    repeat (3) @(negedge clk);
    check("rst ready", o_ready, 1);
    check("rst done", o_done, 0);
    check("rst rd_write", o_rd_write, 0);
    check("rst illegal", o_illegal, 0);
    check("rst result", o_result, 0);
    check("rst request_valid", bus.request_valid, 0);
    check("rst response_ready", bus.response_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);

    ref_mem[12'h300] = 32'h0000_0008;
    run("csrrs_300", 3'b010, 12'h300, 32'h80, 5'd7, 1'b0, 0, 1'b0, -1);
    check("csrrs_300 mem", ref_mem[12'h300], 32'h88);
    run("csrrw_x0_340", 3'b001, 12'h340, 32'h1234, 5'd2, 1'b1, 0, 1'b0, -1);
    run("csrrci_c00_0", 3'b111, 12'hC00, 32'h0, 5'd0, 1'b0, 0, 1'b0, -1);
    run("csrrci_c00_3", 3'b111, 12'hC00, 32'h0, 5'd3, 1'b0, 0, 1'b0, -1);
    run("read_err_300", 3'b010, 12'h300, 32'h1, 5'd4, 1'b0, 0, 1'b1, -1);
    run("csrrw_stall", 3'b001, 12'h340, 32'hDEAD_BEEF, 5'd9, 1'b0, 4, 1'b0, -1);
    run("flush_rd_rsp", 3'b010, 12'h305, 32'hF0, 5'd6, 1'b0, 0, 1'b0, 2);
    run("after_flush", 3'b010, 12'h305, 32'hF0, 5'd6, 1'b0, 0, 1'b0, -1);

    for (int k = 0; k < 40; k++) begin
      a = ($urandom_range(0, 3) == 0) ? 12'($urandom) : addrs[$urandom_range(0, 6)];
      run("rand", f3s[$urandom_range(0, 5)], a, $urandom,
          ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom), 1'($urandom),
          $urandom_range(0, 3), ($urandom_range(0, 7) == 0), -1);
    end

    // Reset in the middle of a stalled request abandons it immediately.
    stall_cfg = 6;
    i_valid = 1'b1; i_funct3 = 3'b001; i_address = 12'h341; i_rs1_value = 32'h55;
    i_uimm = 5'd1; i_rd_zero = 1'b0;
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    check("midrst busy", bus.request_valid, 1);
    rst_n = 1'b0;
    #1;
    check("midrst request_valid", bus.request_valid, 0);
    check("midrst ready", o_ready, 1);
    check("midrst done", o_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run("after_reset", 3'b110, 12'h341, 32'h0, 5'd5, 1'b0, 1, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
